// File: rtl/gb_timer.sv
// DIV/TIMA/TMA/TAC timer peripheral: free-running system counter, selectable
// TIMA tick tap, and a delayed TMA reload with a one-clock interrupt pulse.
module gb_timer #(
  parameter logic [15:0] BASE_ADDR    = 16'hFF04,
  parameter int unsigned RELOAD_DELAY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [7:0]  wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [7:0]  rdata,
  output logic        hit,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, WAIT, RELOAD} state_t;

  localparam logic [2:0] DELAY_INIT = 3'(RELOAD_DELAY - 1);

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [7:0]  tima, tima_nx;
  logic [7:0]  tma;
  logic [2:0]  tac;
  logic [2:0]  count, count_nx;
  logic        tick, tick_q, tap, inc;
  logic [15:0] offset;
  logic        in_range;
  logic        we_div, we_tima, we_tma, we_tac;

  assign offset   = a - BASE_ADDR;
  assign in_range = (offset < 16'd4);
  assign hit      = rd & in_range;

  assign we_div  = wr & in_range & (offset[1:0] == 2'd0);
  assign we_tima = wr & in_range & (offset[1:0] == 2'd1);
  assign we_tma  = wr & in_range & (offset[1:0] == 2'd2);
  assign we_tac  = wr & in_range & (offset[1:0] == 2'd3);

  always_comb begin
    tap = 1'b0;
    case (tac[1:0])
      2'b00: tap = cnt[9];
      2'b01: tap = cnt[3];
      2'b10: tap = cnt[5];
      2'b11: tap = cnt[7];
      default: tap = 1'b0;
    endcase
  end

  // Falling-edge detect on the gated tap, so DIV/TAC writes can also trigger it.
  assign tick = tac[2] & tap;
  assign inc  = tick_q & ~tick;

  always_comb begin
    rdata = 8'hFF;
    if (in_range) begin
      case (offset[1:0])
        2'd0: rdata = cnt[15:8];
        2'd1: rdata = tima;
        2'd2: rdata = tma;
        2'd3: rdata = {5'b11111, tac};
        default: rdata = 8'hFF;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    tima_nx  = tima;
    case (state)
      IDLE: begin
        if (we_tima) begin
          tima_nx = wdata;
        end else if (inc) begin
          if (tima == 8'hFF) begin
            tima_nx  = 8'h00;
            count_nx = DELAY_INIT;
            state_nx = WAIT;
          end else begin
            tima_nx = tima + 8'd1;
          end
        end
      end
      WAIT: begin
        if (we_tima) begin
          tima_nx  = wdata;
          count_nx = '0;
          state_nx = IDLE;
        end else begin
          if (inc) tima_nx = tima + 8'd1;
          if (count == 3'd0) state_nx = RELOAD;
          else               count_nx = count - 3'd1;
        end
      end
      RELOAD: begin
        // A TMA write on this edge reloads TIMA with the value being written.
        tima_nx  = we_tma ? wdata : tma;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      tima   <= '0;
      tma    <= '0;
      tac    <= '0;
      count  <= '0;
      tick_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= we_div ? '0 : cnt + 16'd1;
      tima   <= tima_nx;
      count  <= count_nx;
      tick_q <= tick;
      irq    <= (state == RELOAD);
      if (we_tma) tma <= wdata;
      if (we_tac) tac <= wdata[2:0];
    end
  end

endmodule
